universal_shift_reg: RTL

//  Parametrised successor to the single-bit SISO shift register: WIDTH-bit universal register

---
 rtl/usr_pkg.sv | 13 +
 rtl/shift_word_counter.sv | 36 +++
 rtl/universal_shift_reg.sv | 59 +++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating mode encoding.
package usr_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/shift_word_counter.sv
// Counts shifts within a word and emits a one-cycle pulse when WIDTH shifts complete.
module shift_word_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic at_max;

  assign at_max = (cnt == CNT_MAX);

  // clr wins over inc so a LOAD discards a partial word without flagging it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      wrap_pulse <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      wrap_pulse <= 1'b0;
    end else if (inc) begin
      cnt        <= at_max ? '0 : cnt + 1'b1;
      wrap_pulse <= at_max;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, shift right, shift left, parallel load,
// with a word-boundary counter that flags every WIDTH shifts.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              ser_in,
  input  logic [WIDTH-1:0]  par_in,
  output logic [WIDTH-1:0]  par_out,
  output logic              ser_out_lsb,
  output logic              ser_out_msb,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              word_valid
);

  mode_t            mode_sel;
  logic [WIDTH-1:0] q;
  logic             do_shift;
  logic             do_load;

  assign mode_sel = mode_t'(mode);
  assign do_shift = en && ((mode_sel == MODE_SHR) || (mode_sel == MODE_SHL));
  assign do_load  = en && (mode_sel == MODE_LOAD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      case (mode_sel)
        MODE_SHR:  q <= {ser_in, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], ser_in};
        MODE_LOAD: q <= par_in;
        default:   q <= q;
      endcase
    end
  end

  assign par_out     = q;
  assign ser_out_lsb = q[0];
  assign ser_out_msb = q[WIDTH-1];

  shift_word_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (do_shift),
    .clr       (do_load),
    .cnt       (shift_cnt),
    .wrap_pulse(word_valid)
  );

endmodule
